wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and scoreboard driving the register file's single write port. It merges single-cycle ALU results from the execute stage with results from long-latency units (load/divide), which arrive through a valid/ready handshake into a small buffer. It tracks destination registers with outstanding long-latency results and raises a stall toward decode when a source or destination register is still pending.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- DEPTH, 2, long-latency result buffer entries (power of two, ≥2)

- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- ex_we_i  input  1  execute-stage result valid
- ex_waddr_i  input  ADDR_W  execute-stage destination register
- ex_wdata_i  input  DATA_W  execute-stage result
- ll_valid_i  input  1  long-latency result valid
- ll_ready_o  output  1  buffer can accept a long-latency result
- ll_waddr_i  input  ADDR_W  long-latency destination register
- ll_wdata_i  input  DATA_W  long-latency result
- issue_i  input  1  decode issues a long-latency op this cycle
- issue_rd_i  input  ADDR_W  destination of the issued op
- id_rs1_i, id_rs2_i, id_rd_i  input  ADDR_W each  decode source/destination registers
- stall_o  output  1  decode must hold
- we_o  output  1  register file write enable
- waddr_o  output  ADDR_W  register file write address
- wdata_o  output  DATA_W  register file write data

## Operation
- Buffer: DEPTH-entry FIFO of {waddr, wdata}. Push on ll_valid_i & ll_ready_o. ll_ready_o = !full, registered from state. Not gated by the write-port mux.
- Write-port mux (combinational):
  - ex_we_i=1 and ex_waddr_i≠0: we_o=1, waddr/wdata from ex. The execute stage always has priority and is never back-pressured.
  - Otherwise, if the FIFO is non-empty: we_o=1, waddr/wdata from the FIFO head, and the head is popped at the clock edge.
  - Otherwise we_o=0, waddr_o=0, wdata_o=0.
  - An ex write to x0 is dropped and does not block a FIFO drain.
- A FIFO entry with waddr=0 is popped with we_o=0 and clears no pending bit.
- Simultaneous push and pop on a full FIFO is legal only if ready was already high. Because ready reflects !full, no push occurs while the FIFO is full.
- Scoreboard: a 32-bit pending vector.
  - issue_i with issue_rd_i≠0 sets pending[issue_rd_i].
  - A FIFO pop to register r clears pending[r].
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is always 0.
- stall_o = pending[id_rs1_i] | pending[id_rs2_i] | pending[id_rd_i] (RAW and WAW). The bit of the register being popped this cycle is still counted. There is no bypass from the FIFO.
- Pointers wrap modulo DEPTH. The occupancy counter has width log2(DEPTH)+1.

## Timing
- Reset (rst=0, asynchronous) sets:
  - FIFO empty, pointers 0, pending vector 0
  - ll_ready_o=1, stall_o=0
  - we_o=0, waddr_o=0, wdata_o=0, regardless of the ex inputs
- Ex path latency is 0 cycles: the register file commits at the same clk edge on which ex_we_i is presented.
- LL path:
  - A result pushed at edge N can drive we_o in cycle N+1 at the earliest. It commits at edge N+1 if ex is idle or writing x0.
  - Each cycle of ex activity delays the drain by one cycle.
- Scoreboard timing:
  - A pending bit set at edge N raises stall_o for a matching register from cycle N+1.
  - The bit clears at the pop edge, so stall_o deasserts in the cycle after the write commits.
- Reset asserted mid-operation discards buffered results and pending bits immediately. Writes in flight are lost.

## Test plan
- Reset: hold rst=0 with ex_we_i=1, waddr=5 -> we_o=0, ll_ready_o=1, stall_o=0. After release, ex_we_i=1, waddr=5, wdata=0xA5A5A5A5 -> we_o=1 with the same address and data in the same cycle.
- Priority: push ll {r7, 0x11} while ex writes r3 for 3 consecutive cycles -> r7 appears on the port only in the first cycle after ex goes idle. ll_ready_o stays 1 with one entry buffered.
- Full: DEPTH=2, push {r8, 1}, {r9, 2} with ex busy -> ll_ready_o=0 and a third valid is not accepted. Releasing ex drains r8 then r9 on consecutive cycles, and ready rises after the first pop.
- Scoreboard: issue r10, then id_rs2_i=10 -> stall_o=1 until the ll result for r10 commits, and 0 on the next cycle. In the same cycle as the r10 pop, also issue r10 -> the pending bit stays set and the stall persists.
- x0 handling: ex_we_i=1, waddr=0 with the FIFO holding {r4, 0x44} -> we_o=1, waddr=4. Issue with rd=0 -> no stall. An ll result to r0 is popped with we_o=0.
- Async reset mid-drain: FIFO holds 2 entries and r12 is pending; pulse rst=0 between edges -> outputs go to 0 immediately, the FIFO is empty and stall_o=0 after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges results onto the register file's single write port.
//
// Single-cycle execute results always win the port. Long-latency results
// (load/divide) arrive through a valid/ready handshake into a small FIFO. The
// FIFO drains whenever the execute stage is idle or writing x0. A scoreboard of
// pending destination registers stalls decode on RAW and WAW hazards against
// long-latency results that are still outstanding.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   ex_we_i/ex_waddr_i/ex_wdata_i   execute-stage result (never back-pressured)
//   ll_valid_i/ll_ready_o     long-latency result handshake
//   ll_waddr_i/ll_wdata_i     long-latency result payload
//   issue_i/issue_rd_i        decode issues a long-latency op to issue_rd_i
//   id_rs1_i/id_rs2_i/id_rd_i decode source/destination registers
//   stall_o                   decode must hold
//   we_o/waddr_o/wdata_o      register file write port
module wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ll_valid_i,
    output logic              ll_ready_o,
    input  logic [ADDR_W-1:0] ll_waddr_i,
    input  logic [DATA_W-1:0] ll_wdata_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    output logic              stall_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned NREG = 1 << ADDR_W;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [NREG-1:0]   r_pending;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_pop_wr;
    logic              w_ex_wr;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [NREG-1:0]   w_pending_nxt;

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign ll_ready_o  = !w_full;
    assign w_push      = ll_valid_i & !w_full;

    // Execute writes to x0 are dropped and leave the port free for a drain.
    assign w_ex_wr     = ex_we_i & (ex_waddr_i != '0);
    assign w_pop       = !w_ex_wr & !w_empty;
    assign w_head_addr = r_mem_addr[r_rptr];
    assign w_head_data = r_mem_data[r_rptr];
    // A buffered x0 result is popped silently.
    assign w_pop_wr    = w_pop & (w_head_addr != '0);

    // Outputs are gated by reset so the port is quiet while rst is low,
    // whatever the execute inputs do.
    always_comb begin
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        if (rst) begin
            if (w_ex_wr) begin
                we_o    = 1'b1;
                waddr_o = ex_waddr_i;
                wdata_o = ex_wdata_i;
            end else if (w_pop_wr) begin
                we_o    = 1'b1;
                waddr_o = w_head_addr;
                wdata_o = w_head_data;
            end
        end
    end

    // Payload storage needs no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= ll_waddr_i;
            r_mem_data[r_wptr] <= ll_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear first, then set, so a re-issue to the register being drained wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop_wr) w_pending_nxt[w_head_addr] = 1'b0;
        if (issue_i && (issue_rd_i != '0)) w_pending_nxt[issue_rd_i] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // No bypass from the FIFO: the bit being popped still stalls this cycle.
    assign stall_o = r_pending[id_rs1_i] | r_pending[id_rs2_i] | r_pending[id_rd_i];

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2;

    logic              clk;
    logic              rst;
    logic              ex_we_i;
    logic [ADDR_W-1:0] ex_waddr_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ll_valid_i;
    logic              ll_ready_o;
    logic [ADDR_W-1:0] ll_waddr_i;
    logic [DATA_W-1:0] ll_wdata_i;
    logic              issue_i;
    logic [ADDR_W-1:0] issue_rd_i;
    logic [ADDR_W-1:0] id_rs1_i;
    logic [ADDR_W-1:0] id_rs2_i;
    logic [ADDR_W-1:0] id_rd_i;
    logic              stall_o;
    logic              we_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;

    int n_total;
    int n_bad;

    wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_we_i   (ex_we_i),
        .ex_waddr_i(ex_waddr_i),
        .ex_wdata_i(ex_wdata_i),
        .ll_valid_i(ll_valid_i),
        .ll_ready_o(ll_ready_o),
        .ll_waddr_i(ll_waddr_i),
        .ll_wdata_i(ll_wdata_i),
        .issue_i   (issue_i),
        .issue_rd_i(issue_rd_i),
        .id_rs1_i  (id_rs1_i),
        .id_rs2_i  (id_rs2_i),
        .id_rd_i   (id_rd_i),
        .stall_o   (stall_o),
        .we_o      (we_o),
        .waddr_o   (waddr_o),
        .wdata_o   (wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ex_we_i    = we;
        ex_waddr_i = a;
        ex_wdata_i = d;
    endtask

    task automatic ll_set(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ll_valid_i = v;
        ll_waddr_i = a;
        ll_wdata_i = d;
    endtask

    task automatic port_is(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        check_eq({tag, ".we"}, 64'(we_o), 64'(we));
        check_eq({tag, ".waddr"}, 64'(waddr_o), 64'(a));
        check_eq({tag, ".wdata"}, 64'(wdata_o), 64'(d));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b0;
        ex_set(1'b1, 5'd5, 32'hA5A5_A5A5);
        ll_set(1'b0, '0, '0);
        issue_i = 1'b0; issue_rd_i = '0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;

        // Reset holds the port quiet even with an ex write presented.
        repeat (2) @(posedge clk);
        #1;
        port_is("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst.ready", 64'(ll_ready_o), 64'd1);
        check_eq("rst.stall", 64'(stall_o), 64'd0);
        rst = 1'b1;
        #1;
        port_is("ex_after_rst", 1'b1, 5'd5, 32'hA5A5_A5A5);
        tick();

        // Priority: ex busy for 3 cycles holds off the buffered r7.
        ex_set(1'b1, 5'd3, 32'h33);
        ll_set(1'b1, 5'd7, 32'h11);
        #1;
        port_is("prio.c0", 1'b1, 5'd3, 32'h33);
        tick();
        ll_set(1'b0, '0, '0);
        #1;
        port_is("prio.c1", 1'b1, 5'd3, 32'h33);
        check_eq("prio.ready1", 64'(ll_ready_o), 64'd1);
        tick();
        port_is("prio.c2", 1'b1, 5'd3, 32'h33);
        tick();
        ex_set(1'b0, '0, '0);
        #1;
        port_is("prio.drain", 1'b1, 5'd7, 32'h11);
        tick();
        port_is("prio.idle", 1'b0, 5'd0, 32'd0);

        // Full: two pushes while ex busy, third is refused.
        ex_set(1'b1, 5'd3, 32'h33);
        ll_set(1'b1, 5'd8, 32'd1);
        #1;
        check_eq("full.ready0", 64'(ll_ready_o), 64'd1);
        tick();
        ll_set(1'b1, 5'd9, 32'd2);
        #1;
        check_eq("full.ready1", 64'(ll_ready_o), 64'd1);
        tick();
        ll_set(1'b1, 5'd13, 32'd3);
        #1;
        check_eq("full.ready_low", 64'(ll_ready_o), 64'd0);
        tick();
        ll_set(1'b0, '0, '0);
        ex_set(1'b0, '0, '0);
        #1;
        port_is("full.pop8", 1'b1, 5'd8, 32'd1);
        check_eq("full.ready_pop8", 64'(ll_ready_o), 64'd0);
        tick();
        port_is("full.pop9", 1'b1, 5'd9, 32'd2);
        check_eq("full.ready_pop9", 64'(ll_ready_o), 64'd1);
        tick();
        port_is("full.empty", 1'b0, 5'd0, 32'd0);

        // Scoreboard: r10 pending, re-issued on its own pop edge (set wins).
        issue_i = 1'b1; issue_rd_i = 5'd10; id_rs2_i = 5'd10;
        #1;
        check_eq("sb.stall_pre", 64'(stall_o), 64'd0);
        tick();
        issue_i = 1'b0; issue_rd_i = '0;
        ll_set(1'b1, 5'd10, 32'hAA);
        #1;
        check_eq("sb.stall_set", 64'(stall_o), 64'd1);
        tick();
        ll_set(1'b0, '0, '0);
        issue_i = 1'b1; issue_rd_i = 5'd10;
        #1;
        port_is("sb.pop1", 1'b1, 5'd10, 32'hAA);
        check_eq("sb.stall_pop1", 64'(stall_o), 64'd1);
        tick();
        issue_i = 1'b0; issue_rd_i = '0;
        #1;
        check_eq("sb.stall_setwins", 64'(stall_o), 64'd1);
        ll_set(1'b1, 5'd10, 32'hBB);
        tick();
        ll_set(1'b0, '0, '0);
        #1;
        port_is("sb.pop2", 1'b1, 5'd10, 32'hBB);
        check_eq("sb.stall_pop2", 64'(stall_o), 64'd1);
        tick();
        check_eq("sb.stall_clear", 64'(stall_o), 64'd0);
        // rs1 and rd paths; r11 stays pending until the reset test.
        issue_i = 1'b1; issue_rd_i = 5'd11; id_rs2_i = '0;
        tick();
        issue_i = 1'b0; issue_rd_i = '0; id_rd_i = 5'd11;
        #1;
        check_eq("sb.stall_rd", 64'(stall_o), 64'd1);
        id_rd_i = '0; id_rs1_i = 5'd11;
        #1;
        check_eq("sb.stall_rs1", 64'(stall_o), 64'd1);
        id_rs1_i = '0;
        #1;
        check_eq("sb.stall_none", 64'(stall_o), 64'd0);

        // x0 handling.
        ex_set(1'b1, 5'd0, 32'hDEAD);
        ll_set(1'b1, 5'd4, 32'h44);
        #1;
        port_is("x0.ex_drop", 1'b0, 5'd0, 32'd0);
        tick();
        ll_set(1'b0, '0, '0);
        #1;
        port_is("x0.drain", 1'b1, 5'd4, 32'h44);
        tick();
        ex_set(1'b0, '0, '0);
        issue_i = 1'b1; issue_rd_i = 5'd0;
        tick();
        issue_i = 1'b0;
        #1;
        check_eq("x0.no_stall", 64'(stall_o), 64'd0);
        ll_set(1'b1, 5'd0, 32'h99);
        tick();
        ll_set(1'b0, '0, '0);
        #1;
        port_is("x0.ll_pop", 1'b0, 5'd0, 32'd0);
        tick();
        check_eq("x0.ready", 64'(ll_ready_o), 64'd1);

        // Async reset mid-drain: two entries buffered, r12 pending.
        issue_i = 1'b1; issue_rd_i = 5'd12;
        ex_set(1'b1, 5'd3, 32'h33);
        ll_set(1'b1, 5'd12, 32'hC);
        tick();
        issue_i = 1'b0; issue_rd_i = '0;
        ll_set(1'b1, 5'd5, 32'h55);
        tick();
        ll_set(1'b0, '0, '0);
        id_rs1_i = 5'd12; id_rd_i = 5'd11;
        #1;
        check_eq("arst.ready_pre", 64'(ll_ready_o), 64'd0);
        check_eq("arst.stall_pre", 64'(stall_o), 64'd1);
        rst = 1'b0;
        #1;
        port_is("arst.in", 1'b0, 5'd0, 32'd0);
        check_eq("arst.ready_in", 64'(ll_ready_o), 64'd1);
        rst = 1'b1;
        ex_set(1'b0, '0, '0);
        #1;
        port_is("arst.empty", 1'b0, 5'd0, 32'd0);
        check_eq("arst.stall", 64'(stall_o), 64'd0);
        tick();
        port_is("arst.empty2", 1'b0, 5'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
